// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: owner encoding,
// default starvation limit and the age counter width.
package imem_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 3;
  localparam int unsigned AGE_W            = 3;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_DERR  = 2'd3
  } owner_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_arb_age.sv
// Saturating count of consecutive cycles a data request has lost arbitration.
module imem_arb_age
  import imem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [AGE_W-1:0] LIM = AGE_W'(LIMIT);

  logic [AGE_W-1:0] r_age;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_age <= '0;
    end else if (inc && (r_age != LIM)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign at_limit = (r_age == LIM);

endmodule

// File: rtl/imem_arb.sv
// Arbitrates the single I-Memory read port between instruction fetch and
// data-side word reads, and routes the one-cycle-late response to its owner.
module imem_arb
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_redirect,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_rq,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
);

  logic   w_at_limit;
  logic   w_fetch_gnt;
  logic   w_data_gnt;
  logic   w_data_ok;
  owner_t w_owner_nxt;
  owner_t r_owner;

  // Redirects beat an aged data request; otherwise aging forces data through.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!reset) begin
      if (fetch_req && fetch_redirect) begin
        w_fetch_gnt = 1'b1;
      end else if (data_req && (!fetch_req || w_at_limit)) begin
        w_data_gnt = 1'b1;
      end else if (fetch_req) begin
        w_fetch_gnt = 1'b1;
      end
    end
  end

  assign w_data_ok = w_data_gnt && is_word_aligned(data_addr);

  imem_arb_age #(
    .LIMIT(STARVE_LIMIT)
  ) u_age (
    .clk     (clk),
    .reset   (reset),
    .inc     (data_req && !w_data_gnt),
    .clr     (w_data_gnt || !data_req),
    .at_limit(w_at_limit)
  );

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_fetch_gnt) begin
      w_owner_nxt = OWN_FETCH;
    end else if (w_data_ok) begin
      w_owner_nxt = OWN_DATA;
    end else if (w_data_gnt) begin
      w_owner_nxt = OWN_DERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  assign fetch_gnt = w_fetch_gnt;
  assign data_gnt  = w_data_gnt;
  assign mem_rq    = w_fetch_gnt || w_data_ok;
  assign mem_addr  = w_data_ok ? data_addr : fetch_addr;

  // Responses are masked during reset so a pending one is dropped.
  assign fetch_rvalid = !reset && (r_owner == OWN_FETCH);
  assign data_rvalid  = !reset && ((r_owner == OWN_DATA) || (r_owner == OWN_DERR));
  assign data_err     = !reset && (r_owner == OWN_DERR);
  assign data_rdata   = (!reset && (r_owner == OWN_DATA)) ? mem_data : '0;

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, is the number of consecutive cycles a data request may lose to fetch before it is forced to win (range 1..7).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fetch_req  in  1  fetch FIFO read request (FIFO mem_rq).
REQ-005 fetch_addr  in  32  fetch address, halfword-aligned, passed to memory unmodified.
REQ-006 fetch_redirect  in  1  current fetch_req carries a redirect target.
REQ-007 fetch_gnt  out  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid  out  1  mem_data holds fetch response this cycle.
REQ-009 data_req  in  1  data-side word read request from I-Memory.
REQ-010 data_addr  in  32  data read address; must be word-aligned.
REQ-011 data_gnt  out  1  data request accepted this cycle.
REQ-012 data_rvalid  out  1  data response valid this cycle.
REQ-013 data_rdata  out  32  data response word.
REQ-014 data_err  out  1  data response is a misalignment error.
REQ-015 mem_rq  out  1  I-Memory read strobe.
REQ-016 mem_addr  out  32  I-Memory address.
REQ-017 mem_data  in  32  I-Memory read data, valid one cycle after mem_rq.

Function
REQ-018 At most one of fetch_gnt, data_gnt SHALL be 1 in any cycle; grants are combinational from current-cycle requests.
REQ-019 Priority SHALL be: fetch_req&fetch_redirect -> fetch; else data_req&(~fetch_req | age==STARVE_LIMIT) -> data; else fetch_req -> fetch; else no grant.
REQ-020 age SHALL increment (saturating at STARVE_LIMIT) each cycle data_req=1 and data_gnt=0, and clear to 0 on data_gnt or data_req=0.
REQ-021 Continuous redirects SHALL override aging; data starvation under back-to-back redirects is permitted.
REQ-022 On fetch_gnt: mem_rq=1, mem_addr=fetch_addr.
REQ-023 On data_gnt with data_addr[1:0]==0: mem_rq=1, mem_addr=data_addr.
REQ-024 On data_gnt with data_addr[1:0]!=0: mem_rq=0, mem_addr=fetch_addr, error response scheduled.
REQ-025 With no grant: mem_rq=0, mem_addr=fetch_addr.
REQ-026 A registered owner state {NONE, FETCH, DATA, DERR} SHALL record the grant each cycle; NONE when no grant.
REQ-027 owner==FETCH: fetch_rvalid=1 exactly one cycle after fetch_gnt.
REQ-028 owner==DATA: data_rvalid=1, data_rdata=mem_data, data_err=0.
REQ-029 owner==DERR: data_rvalid=1, data_err=1, data_rdata=0.
REQ-030 Otherwise data_rdata=0, data_err=0, rvalids=0; fetch_rvalid and data_rvalid never both 1.
REQ-031 Full throughput: a new grant is allowed every cycle, including in the response cycle of the previous grant.
REQ-032 Requester SHALL hold data_req and data_addr stable until data_gnt; early withdrawal is legal, clears age, issues nothing.
REQ-033 fetch_redirect arriving while a fetch response is outstanding SHALL NOT cancel it; fetch_rvalid still asserts (FIFO discards).

Reset
REQ-034 While reset=1: all grants, mem_rq, rvalids, data_err=0; data_rdata=0; mem_addr=fetch_addr; age=0; owner=NONE.
REQ-035 Reset asserted in a response cycle's preceding cycle SHALL drop that response: no rvalid in the cycle after reset.
REQ-036 First grant possible in the first cycle with reset=0.

Structure
REQ-037 Package imem_arb_pkg SHALL hold the owner state encoding (OWN_NONE, OWN_FETCH, OWN_DATA, OWN_DERR) and the STARVE_LIMIT default.
REQ-038 Saturating age counter SHALL be sub-module imem_arb_age (inputs inc, clr; output at_limit).

Verification
REQ-039 fetch_req=1 continuous, data_req=1 at addr 0x100 from cycle 0, STARVE_LIMIT=3 -> data_gnt in cycle 3, data_rvalid cycle 4 with data_rdata=mem_data.
REQ-040 Same as 039 plus fetch_redirect=1 every cycle -> data_gnt never asserted, age holds 3.
REQ-041 data_req alone, data_addr=0x102 -> data_gnt=1, mem_rq=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
REQ-042 fetch_gnt at addr 0x40 cycle N, data_gnt at 0x80 cycle N+1 -> fetch_rvalid N+1, data_rvalid N+2, never both.
REQ-043 fetch_gnt cycle N, reset=1 cycle N+1 -> fetch_rvalid=0 cycles N+1, N+2; all outputs 0.
REQ-044 data_req raised 2 cycles under fetch, dropped, raised again -> age restarts at 0; grant after 3 further losing cycles.
